// File: rtl/pio_input_debouncer_pkg.sv
// pio_debounce_pkg: shared state encodings and counter sizing for the PIO input debouncer
package pio_debounce_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_CHECK = 1'b1} state_e;
  function automatic int cnt_w(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
endpackage

// File: rtl/pio_input_debouncer_if.sv
// pio_input_debouncer_if: raw pin inputs and conditioned level/edge outputs of the debouncer
interface pio_input_debouncer_if #(parameter int WIDTH = 5);
  logic [WIDTH-1:0] raw_in;
  logic             enable;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] busy;
  modport master (output raw_in, enable, input clean_out, rise_pulse, fall_pulse, busy);
  modport slave (input raw_in, enable, output clean_out, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/pio_input_debouncer_channel.sv
// debounce_channel: one-bit synchroniser, stability FSM and committed level/edge registers
module debounce_channel
  import pio_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 100,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic enable,
  input  logic tick,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CW = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic sync1, sync2;
  state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic clean_n, rise_n, fall_n;
  // two-flop synchroniser runs regardless of enable so the sampled level is always fresh
  always_ff @(posedge clk)
    if (reset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  // state, stability counter and committed level/pulse registers
  always_ff @(posedge clk)
    if (reset) begin
      st    <= ST_IDLE;
      cnt   <= '0;
      clean <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      clean <= clean_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  // a differing level must survive STABLE_TICKS ticks; returning to the committed level aborts the check
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    clean_n = clean;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (!enable) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else if (st == ST_IDLE) begin
      st_n  = (sync2 != clean) ? ST_CHECK : ST_IDLE;
      cnt_n = '0;
    end else if (sync2 == clean) begin
      st_n  = ST_IDLE;
      cnt_n = '0;
    end else if (tick) begin
      if (cnt == LAST) begin
        st_n    = ST_IDLE;
        cnt_n   = '0;
        clean_n = sync2;
        rise_n  = sync2;
        fall_n  = ~sync2;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end
  assign busy = (st == ST_CHECK);
endmodule

// File: rtl/pio_input_debouncer.sv
// pio_input_debouncer: shared sample-tick prescaler feeding WIDTH independent debounce channels
module pio_input_debouncer
  import pio_debounce_pkg::*;
#(
  parameter int   WIDTH        = 5,
  parameter int   TICK_DIV     = 500,
  parameter int   STABLE_TICKS = 100,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input logic clk,
  input logic reset,
  pio_input_debouncer_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pcnt;
  logic tick;
  logic [WIDTH-1:0] clean, rise, fall, busy;
  assign tick = bus.enable && (pcnt == PW'(TICK_DIV - 1));
  // prescaler parks at zero while disabled so re-enabling always starts a fresh tick period
  always_ff @(posedge clk)
    if (reset || !bus.enable) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PW'(1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.STABLE_TICKS(STABLE_TICKS), .RESET_LEVEL(RESET_LEVEL)) u_ch (
      .clk(clk), .reset(reset), .raw(bus.raw_in[i]), .enable(bus.enable), .tick(tick),
      .clean(clean[i]), .rise(rise[i]), .fall(fall[i]), .busy(busy[i])
    );
  end
  assign bus.clean_out  = clean;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_pio_input_debouncer.sv
// tb_pio_input_debouncer: directed scoreboard bench for the PIO input debouncer
module tb_pio_input_debouncer;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
  int k;
  logic [4:0] acc;
  typedef struct {string tag; logic [4:0] clean, rise, fall;} exp_t;
  exp_t sb[$];
  pio_input_debouncer_if #(.WIDTH(5)) bus();
  pio_input_debouncer #(.WIDTH(5), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic wait_clean(input logic [4:0] m, input logic [4:0] v, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      if ((bus.clean_out & m) == (v & m)) begin
        cyc = n;
        return;
      end
    end
  endtask
  task automatic sb_check(input logic [4:0] pulse_rise, input logic [4:0] pulse_fall);
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_clean"}, 32'(bus.clean_out), 32'(e.clean));
    chk({e.tag, "_rise"}, 32'(pulse_rise), 32'(e.rise));
    chk({e.tag, "_fall"}, 32'(pulse_fall), 32'(e.fall));
  endtask
  task automatic watch(input int n, output logic [4:0] pulses);
    pulses = '0;
    repeat (n) begin
      step(1);
      pulses |= bus.rise_pulse | bus.fall_pulse;
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.raw_in = 5'h1F;
    bus.enable = 1'b1;
    step(1);
    chk("t1_rst_clean", 32'(bus.clean_out), 0);
    chk("t1_rst_rise", 32'(bus.rise_pulse), 0);
    chk("t1_rst_fall", 32'(bus.fall_pulse), 0);
    chk("t1_rst_busy", 32'(bus.busy), 0);
    step(2);
    reset = 1'b0;
    step(2);
    chk("t1_busy_early", 32'(bus.busy), 0);
    step(1);
    chk("t1_busy", 32'(bus.busy), 32'h1F);
    reset = 1'b1;
    bus.raw_in = 5'h00;
    step(3);
    reset = 1'b0;
    step(3);
    chk("t1_quiet_busy", 32'(bus.busy), 0);
    chk("t1_quiet_clean", 32'(bus.clean_out), 0);
    sb.push_back('{"t2", 5'b00001, 5'b00001, 5'b00000});
    bus.raw_in = 5'b00001;
    wait_clean(5'b00001, 5'b00001, k);
    chk("t2_latency_ok", 32'(k - 1 >= 11 && k - 1 <= 14), 1);
    sb_check(bus.rise_pulse, bus.fall_pulse);
    step(1);
    chk("t2_rise_one_cycle", 32'(bus.rise_pulse), 0);
    sb.push_back('{"t3", 5'b00001, 5'b00000, 5'b00000});
    bus.raw_in = 5'b00011;
    step(6);
    chk("t3_busy_glitch", 32'(bus.busy), 32'b00010);
    bus.raw_in = 5'b00001;
    step(3);
    chk("t3_busy_back", 32'(bus.busy), 0);
    watch(20, acc);
    sb_check(acc, 5'b00000);
    sb.push_back('{"t4", 5'b00101, 5'b00100, 5'b00000});
    bus.raw_in = 5'b00101;
    step(5);
    chk("t4_busy_before_off", 32'(bus.busy), 32'b00100);
    bus.enable = 1'b0;
    watch(20, acc);
    chk("t4_off_pulses", 32'(acc), 0);
    chk("t4_off_clean", 32'(bus.clean_out), 32'b00001);
    chk("t4_off_busy", 32'(bus.busy), 0);
    bus.enable = 1'b1;
    wait_clean(5'b00100, 5'b00100, k);
    chk("t4_latency_ok", 32'(k - 1 >= 11 && k - 1 <= 14), 1);
    sb_check(bus.rise_pulse, bus.fall_pulse);
    bus.raw_in = 5'h00;
    wait_clean(5'h1F, 5'h00, k);
    chk("t5_clear_done", 32'(k > 0), 1);
    step(2);
    sb.push_back('{"t5_up", 5'h1F, 5'h1F, 5'h00});
    bus.raw_in = 5'h1F;
    wait_clean(5'h1F, 5'h1F, k);
    sb_check(bus.rise_pulse, bus.fall_pulse);
    step(1);
    chk("t5_rise_one_cycle", 32'(bus.rise_pulse), 0);
    sb.push_back('{"t5_dn", 5'h00, 5'h00, 5'h1F});
    bus.raw_in = 5'h00;
    wait_clean(5'h1F, 5'h00, k);
    sb_check(bus.rise_pulse, bus.fall_pulse);
    step(1);
    chk("t5_fall_one_cycle", 32'(bus.fall_pulse), 0);
    bus.raw_in = 5'b01000;
    wait_clean(5'b01000, 5'b01000, k);
    chk("t6_commit", 32'(k > 0), 1);
    step(2);
    bus.raw_in = 5'b00000;
    step(5);
    chk("t6_busy3", 32'(bus.busy), 32'b01000);
    sb.push_back('{"t6", 5'h00, 5'h00, 5'h00});
    reset = 1'b1;
    step(1);
    sb_check(bus.rise_pulse, bus.fall_pulse);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    watch(20, acc);
    chk("t6_after_pulses", 32'(acc), 0);
    chk("t6_after_clean", 32'(bus.clean_out), 0);
    chk("t6_after_busy", 32'(bus.busy), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
